// File: rtl/dram_resp.sv
// Data-RAM port responder for the hxd32 core: block RAM with 1-cycle registered reads,
// byte-enabled writes, and a 16-byte MMIO window (cycle counter, tohost, scratch).
module dram_resp #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 4096,
    parameter logic [XLEN-1:0]  RAM_BASE  = 32'h0000_0000,
    parameter logic [XLEN-1:0]  MMIO_BASE = 32'h1000_0000
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] dram_rd_addr_i,
    output logic [XLEN-1:0] dram_rd_data_o,
    input  logic [XLEN-1:0] dram_wr_addr_i,
    input  logic [XLEN-1:0] dram_wr_data_i,
    input  logic [3:0]      dram_wr_byte_en_i,
    output logic [XLEN-1:0] tohost_o,
    output logic            tohost_vld_o,
    output logic            err_o
);
    localparam int                AW        = $clog2(DEPTH);
    localparam logic [XLEN-1:0]   RAM_BYTES = XLEN'(4 * DEPTH);
    localparam logic [XLEN-1:0]   MMIO_SIZE = XLEN'(16);
    localparam logic [2*XLEN-1:0] CYC_ONE   = 1;

    typedef enum logic [1:0] {
        REG_CYC_LO  = 2'd0,
        REG_CYC_HI  = 2'd1,
        REG_TOHOST  = 2'd2,
        REG_SCRATCH = 2'd3
    } reg_sel_e;

    logic [XLEN-1:0]   mem [DEPTH];

    logic [XLEN-1:0]   rd_ram_off, rd_mmio_off, wr_ram_off, wr_mmio_off;
    logic              rd_ram_hit, rd_mmio_hit, rd_oor;
    logic              wr_ram_hit, wr_mmio_hit, wr_oor, wr_en;
    logic [AW-1:0]     rd_idx, wr_idx;
    reg_sel_e          rd_sel, wr_sel;
    logic [XLEN-1:0]   rd_next;

    logic [XLEN-1:0]   rd_data_q;
    logic [2*XLEN-1:0] cycle_q;
    logic [XLEN-1:0]   shadow_q, tohost_q, scratch_q;
    logic              tohost_vld_q, err_q;

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                    input logic [XLEN-1:0] new_v,
                                                    input logic [3:0]      be);
        logic [XLEN-1:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    // Unsigned offset compare alone covers addresses below the base, since they wrap high.
    always_comb begin
        rd_ram_off  = dram_rd_addr_i - RAM_BASE;
        rd_mmio_off = dram_rd_addr_i - MMIO_BASE;
        wr_ram_off  = dram_wr_addr_i - RAM_BASE;
        wr_mmio_off = dram_wr_addr_i - MMIO_BASE;
        rd_ram_hit  = rd_ram_off < RAM_BYTES;
        rd_mmio_hit = rd_mmio_off < MMIO_SIZE;
        wr_ram_hit  = wr_ram_off < RAM_BYTES;
        wr_mmio_hit = wr_mmio_off < MMIO_SIZE;
        rd_oor      = !rd_ram_hit && !rd_mmio_hit;
        wr_oor      = !wr_ram_hit && !wr_mmio_hit;
        rd_idx      = rd_ram_off[AW+1:2];
        wr_idx      = wr_ram_off[AW+1:2];
        rd_sel      = reg_sel_e'(rd_mmio_off[3:2]);
        wr_sel      = reg_sel_e'(wr_mmio_off[3:2]);
        wr_en       = rst_n_i && (dram_wr_byte_en_i != 4'b0000);
    end

    always_comb begin
        rd_next = '0;
        if (rd_ram_hit) begin
            rd_next = mem[rd_idx];
        end else if (rd_mmio_hit) begin
            case (rd_sel)
                REG_CYC_LO:  rd_next = cycle_q[XLEN-1:0];
                REG_CYC_HI:  rd_next = shadow_q;
                REG_TOHOST:  rd_next = tohost_q;
                REG_SCRATCH: rd_next = scratch_q;
                default:     rd_next = '0;
            endcase
        end
    end

    // RAM array has no reset; the read mux above samples it before this edge's write lands.
    always_ff @(posedge clk_i) begin
        if (wr_en && wr_ram_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (dram_wr_byte_en_i[k]) mem[wr_idx][8*k +: 8] <= dram_wr_data_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_data_q    <= '0;
            cycle_q      <= '0;
            shadow_q     <= '0;
            tohost_q     <= '0;
            scratch_q    <= '0;
            tohost_vld_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_data_q <= rd_next;
            cycle_q   <= cycle_q + CYC_ONE;
            if (rd_mmio_hit && rd_sel == REG_CYC_LO) shadow_q <= cycle_q[2*XLEN-1:XLEN];
            if (wr_en && wr_mmio_hit && wr_sel == REG_TOHOST)
                tohost_q <= merge_bytes(tohost_q, dram_wr_data_i, dram_wr_byte_en_i);
            if (wr_en && wr_mmio_hit && wr_sel == REG_SCRATCH)
                scratch_q <= merge_bytes(scratch_q, dram_wr_data_i, dram_wr_byte_en_i);
            tohost_vld_q <= wr_en && wr_mmio_hit && (wr_sel == REG_TOHOST);
            if (rd_oor || (wr_en && wr_oor)) err_q <= 1'b1;
        end
    end

    assign dram_rd_data_o = rd_data_q;
    assign tohost_o       = tohost_q;
    assign tohost_vld_o   = tohost_vld_q;
    assign err_o          = err_q;
endmodule
